hex_uart_dumper: RTL and testbench

//  Captures a W-bit result word (e.g. a keccak digest) on a valid/ready handshake and transmits
//  it as lowercase ASCII hex over a simplex 8N1 UART line, one character per nibble.

---
 rtl/hex_dump_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 60 ++++++
 rtl/hex_uart_dumper.sv | 171 +++++++++++++++++
 tb/tb_hex_uart_dumper.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_dump_pkg.sv
// Shared types and helpers for the hex UART dumper.
// Optional feature macro: HEX_UART_DUMPER_CRLF_EN adds the CR/LF terminator states.
package hex_dump_pkg;

  // Dumper FSM states; the terminator states only exist when CR/LF output is built in
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
`ifdef HEX_UART_DUMPER_CRLF_EN
    ST_TERM_CR = 3'd4,
    ST_TERM_LF = 3'd5,
`endif
    ST_FIN     = 3'd3
  } dump_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex digit: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each CPB clocks.
// byte_valid is taken only while idle; byte_done is high during the last stop-bit cycle,
// so a byte offered in the following cycle starts after exactly one idle-high cycle.
module uart_tx_byte #(
  parameter int CPB = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       tx
);

  localparam int TW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CPB - 1);

  logic          active_reg;
  logic [TW-1:0] timer_reg;
  logic [3:0]    bit_idx_reg;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    frame_reg;     // remaining data bits followed by the stop bit
  logic          tx_reg;
  logic          bit_end;

  assign bit_end   = (timer_reg == TIMER_LAST);
  assign byte_done = active_reg && (bit_idx_reg == 4'd9) && bit_end;
  assign tx        = tx_reg;

  // Bit timer and frame shifter; the line is forced high the moment reset asserts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_reg  <= 1'b0;
      timer_reg   <= '0;
      bit_idx_reg <= 4'd0;
      frame_reg   <= '1;
      tx_reg      <= 1'b1;
    end else if (!active_reg) begin
      if (byte_valid) begin
        active_reg  <= 1'b1;
        timer_reg   <= '0;
        bit_idx_reg <= 4'd0;
        frame_reg   <= {1'b1, byte_data};
        tx_reg      <= 1'b0;
      end
    end else if (bit_end) begin
      timer_reg <= '0;
      if (bit_idx_reg == 4'd9) begin
        active_reg <= 1'b0;
        tx_reg     <= 1'b1;
      end else begin
        tx_reg      <= frame_reg[0];
        frame_reg   <= {1'b1, frame_reg[8:1]};
        bit_idx_reg <= bit_idx_reg + 4'd1;
      end
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hex_uart_dumper.sv
// Handshaked hex dumper: captures a W-bit word and streams it as lowercase ASCII hex
// over an 8N1 UART line, one character per nibble, then pulses done.
// Build option: define HEX_UART_DUMPER_CRLF_EN to append CR LF after the last digit.
module hex_uart_dumper #(
  parameter int W         = 512,
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD      = 9600,
  parameter int MSN_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] data,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  import hex_dump_pkg::*;

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int NCHAR = W / 4;
  localparam int CW    = $clog2(NCHAR + 1);

  if ((W % 4) != 0 || W < 4) begin : g_bad_width
    $error("hex_uart_dumper: W must be a positive multiple of 4");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("hex_uart_dumper: CLK_FREQ/BAUD must be at least 2");
  end

  dump_state_t   state_reg;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  shift_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          start_ready_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [3:0]    cur_nibble;
  logic          last_char;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_done;
`ifdef HEX_UART_DUMPER_CRLF_EN
  logic          term_issued_reg;  // terminator byte already handed to the serializer
`endif

  // Nibble order: most significant first reads naturally, least significant first is raw order
  if (MSN_FIRST != 0) begin : g_msn
    assign cur_nibble = shift_reg[W-1 -: 4];
    assign shift_next = shift_reg << 4;
  end else begin : g_lsn
    assign cur_nibble = shift_reg[3:0];
    assign shift_next = shift_reg >> 4;
  end

  assign count_next  = count_reg + 1'b1;
  assign last_char   = (count_next == CW'(NCHAR));
  assign start_ready = start_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

  // Byte offered to the serializer: one cycle per character, decoded from registered state
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = nibble_to_ascii(cur_nibble);
    case (state_reg)
      ST_LOAD: byte_valid = 1'b1;
`ifdef HEX_UART_DUMPER_CRLF_EN
      ST_TERM_CR: begin
        byte_valid = !term_issued_reg;
        byte_data  = ASCII_CR;
      end
      ST_TERM_LF: begin
        byte_valid = !term_issued_reg;
        byte_data  = ASCII_LF;
      end
`endif
      default: byte_valid = 1'b0;
    endcase
  end

  // Dump sequencer with registered handshake, busy and done outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      count_reg       <= '0;
      start_ready_reg <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
`ifdef HEX_UART_DUMPER_CRLF_EN
      term_issued_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_valid && start_ready_reg) begin
            shift_reg       <= data;
            count_reg       <= '0;
            start_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (byte_done) begin
            shift_reg <= shift_next;
            count_reg <= count_next;
            if (last_char) begin
`ifdef HEX_UART_DUMPER_CRLF_EN
              term_issued_reg <= 1'b0;
              state_reg       <= ST_TERM_CR;
`else
              done_reg  <= 1'b1;
              state_reg <= ST_FIN;
`endif
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end
`ifdef HEX_UART_DUMPER_CRLF_EN
        ST_TERM_CR: begin
          if (!term_issued_reg) begin
            term_issued_reg <= 1'b1;
          end else if (byte_done) begin
            term_issued_reg <= 1'b0;
            state_reg       <= ST_TERM_LF;
          end
        end
        ST_TERM_LF: begin
          if (!term_issued_reg) begin
            term_issued_reg <= 1'b1;
          end else if (byte_done) begin
            term_issued_reg <= 1'b0;
            done_reg        <= 1'b1;
            state_reg       <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          start_ready_reg <= 1'b1;
          busy_reg        <= 1'b0;
          state_reg       <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CPB(CPB)
  ) u_uart_tx_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .tx        (tx)
  );

endmodule

// File: tb/tb_hex_uart_dumper.sv
// Scoreboard bench for hex_uart_dumper: W=16, CPB=10, one instance per nibble order.
// Expected UART bytes are queued when a dump is issued; a receiver per instance decodes
// the line and pops/compares independently of the stimulus.
module tb_hex_uart_dumper;

  localparam int W        = 16;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int CPB      = 10;
  localparam int P        = 10 * CPB + 1;
`ifdef HEX_UART_DUMPER_CRLF_EN
  localparam int NBYTES   = 6;
`else
  localparam int NBYTES   = 4;
`endif
  localparam int DUMP_CYC = NBYTES * P + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sv_a = 1'b0, sv_b = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic         ready_a, busy_a, done_a, tx_a;
  logic         ready_b, busy_b, done_b, tx_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit rx_ignore = 1'b0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  hex_uart_dumper #(.W(W), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MSN_FIRST(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_valid(sv_a), .start_ready(ready_a),
    .data(data_a), .busy(busy_a), .done(done_a), .tx(tx_a));

  hex_uart_dumper #(.W(W), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MSN_FIRST(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_valid(sv_b), .start_ready(ready_b),
    .data(data_b), .busy(busy_b), .done(done_b), .tx(tx_b));

  function automatic logic sig_ready(input int w); return (w == 0) ? ready_a : ready_b; endfunction
  function automatic logic sig_busy(input int w);  return (w == 0) ? busy_a  : busy_b;  endfunction
  function automatic logic sig_done(input int w);  return (w == 0) ? done_a  : done_b;  endfunction
  function automatic logic sig_tx(input int w);    return (w == 0) ? tx_a    : tx_b;    endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Queue the four hand-computed characters of one word (plus CR LF when built in)
  task automatic push(input int w, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] seq[$];
    seq = '{b0, b1, b2, b3};
`ifdef HEX_UART_DUMPER_CRLF_EN
    seq.push_back(8'h0D);
    seq.push_back(8'h0A);
`endif
    foreach (seq[i]) begin
      if (w == 0) exp_a.push_back(seq[i]);
      else        exp_b.push_back(seq[i]);
    end
  endtask

  // Receive one frame; entered on the first falling-edge sample of the start bit
  task automatic rx_frame(input int w, output logic [7:0] b, output logic stop);
    b = '0;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = sig_tx(w);
    end
    repeat (CPB) @(negedge clk);
    stop = sig_tx(w);
  endtask

  task automatic score(input int w, input logic [7:0] b, input logic stop);
    logic [7:0] e;
    check((w == 0) ? "rx_a_stop_bit" : "rx_b_stop_bit", 32'(stop), 32'd1);
    if ((w == 0 && exp_a.size() == 0) || (w != 0 && exp_b.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_%0d_unexpected: got byte %02h, required no byte", w, b);
    end else begin
      e = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
      $display("[TB] dut_%s rx byte %02h expected %02h", (w == 0) ? "a" : "b", b, e);
      check((w == 0) ? "rx_a_byte" : "rx_b_byte", 32'(b), 32'(e));
    end
  endtask

  initial begin : mon_a
    logic [7:0] b;
    logic stop;
    forever begin
      @(negedge clk);
      if (reset_n && tx_a === 1'b0) begin
        rx_frame(0, b, stop);
        if (!rx_ignore) score(0, b, stop);
      end
    end
  end

  initial begin : mon_b
    logic [7:0] b;
    logic stop;
    forever begin
      @(negedge clk);
      if (reset_n && tx_b === 1'b0) begin
        rx_frame(1, b, stop);
        if (!rx_ignore) score(1, b, stop);
      end
    end
  end

  // Count cycles from acceptance to done (bounded), then check the post-dump idle cycle
  task automatic wait_done(input int w, input int start_cyc, input string tag);
    int cyc;
    cyc = start_cyc;
    while (!sig_done(w) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(DUMP_CYC));
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(sig_done(w)), 32'd0);
    check({tag, "_ready_after"}, 32'(sig_ready(w)), 32'd1);
    check({tag, "_busy_after"}, 32'(sig_busy(w)), 32'd0);
  endtask

  task automatic run_dump(input int w, input logic [W-1:0] d, input string tag);
    @(negedge clk);
    check({tag, "_ready_before"}, 32'(sig_ready(w)), 32'd1);
    if (w == 0) begin sv_a = 1'b1; data_a = d; end
    else        begin sv_b = 1'b1; data_b = d; end
    @(posedge clk);
    @(negedge clk);
    if (w == 0) sv_a = 1'b0; else sv_b = 1'b0;
    check({tag, "_busy"}, 32'(sig_busy(w)), 32'd1);
    check({tag, "_ready_busy"}, 32'(sig_ready(w)), 32'd0);
    wait_done(w, 1, tag);
    check({tag, "_queue_empty"}, 32'((w == 0) ? exp_a.size() : exp_b.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  cyc;
    bit  saw_done;

    // 1: reset values, held and after release
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_tx", 32'(sig_tx(w)), 32'd1);
      check("rst_ready", 32'(sig_ready(w)), 32'd1);
      check("rst_busy", 32'(sig_busy(w)), 32'd0);
      check("rst_done", 32'(sig_done(w)), 32'd0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rel_tx", 32'(sig_tx(w)), 32'd1);
      check("rel_ready", 32'(sig_ready(w)), 32'd1);
      check("rel_busy", 32'(sig_busy(w)), 32'd0);
    end

    // 2: most significant nibble first
    push(0, 8'h61, 8'h35, 8'h66, 8'h30);
    run_dump(0, 16'hA5F0, "t2_msn");

    // 3: least significant nibble first, two words
    push(1, 8'h30, 8'h66, 8'h35, 8'h61);
    run_dump(1, 16'hA5F0, "t3_lsn");
    push(1, 8'h39, 8'h38, 8'h37, 8'h36);
    run_dump(1, 16'h6789, "t3_lsn2");

    // 4: start_valid held with new data during a dump
    push(0, 8'h61, 8'h35, 8'h66, 8'h30);
    push(0, 8'h33, 8'h63, 8'h37, 8'h64);
    @(negedge clk);
    check("t4_ready_before", 32'(ready_a), 32'd1);
    sv_a = 1'b1;
    data_a = 16'hA5F0;
    @(posedge clk);
    @(negedge clk);
    data_a = 16'h3C7D;
    check("t4_ready_busy", 32'(ready_a), 32'd0);
    wait_done(0, 1, "t4_first");
    @(posedge clk);
    @(negedge clk);
    sv_a = 1'b0;
    check("t4_second_busy", 32'(busy_a), 32'd1);
    wait_done(0, 1, "t4_second");
    check("t4_queue_empty", 32'(exp_a.size()), 32'd0);

    // 5: reset during the start bit of the second character
    push(0, 8'h31, 8'h32, 8'h33, 8'h34);
    @(negedge clk);
    sv_a = 1'b1;
    data_a = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    sv_a = 1'b0;
    cyc = 1;
    while (cyc < 106) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_tx_low_before_reset", 32'(tx_a), 32'd0);
    check("t5_first_char_only", 32'(exp_a.size()), 32'd3);
    rx_ignore = 1'b1;
    exp_a.delete();
    reset_n = 1'b0;
    #1;
    check("t5_tx_async_high", 32'(tx_a), 32'd1);
    check("t5_ready_in_reset", 32'(ready_a), 32'd1);
    check("t5_busy_in_reset", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    check("t5_no_done", 32'(saw_done), 32'd0);
    rx_ignore = 1'b0;
    push(0, 8'h62, 8'h65, 8'h65, 8'h66);
    run_dump(0, 16'hBEEF, "t5_after");

`ifdef HEX_UART_DUMPER_CRLF_EN
    // 6: CR LF terminator after the digits
    push(0, 8'h30, 8'h30, 8'h66, 8'h66);
    run_dump(0, 16'h00FF, "t6_crlf");
`endif

    repeat (5) @(negedge clk);
    check("final_queue_a", 32'(exp_a.size()), 32'd0);
    check("final_queue_b", 32'(exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
